// File: rtl/bsg_link_downstream_arbiter.sv
// Packet-aware round-robin merge of downstream link channels onto one valid/yumi consumer port.
// Optional stall watchdog: define BSG_LINK_DOWNSTREAM_ARBITER_WATCHDOG_EN.
module bsg_link_downstream_arbiter #(
  parameter int channel_width_p   = 16,
  parameter int num_channels_p    = 4,
  parameter int len_width_p       = 4,
  parameter int len_offset_p      = 0,
  parameter int watchdog_cycles_p = 255,
  localparam int id_width_lp = (num_channels_p > 1) ? $clog2(num_channels_p) : 1
) (
  input  logic                                      clk_i,
  input  logic                                      reset_i,
  input  logic [num_channels_p-1:0]                 valid_i,
  input  logic [num_channels_p*channel_width_p-1:0] data_i,
  output logic [num_channels_p-1:0]                 yumi_o,
  output logic                                      valid_o,
  output logic [channel_width_p-1:0]                data_o,
  output logic [id_width_lp-1:0]                    grant_id_o,
  input  logic                                      yumi_i,
  output logic                                      error_o
);

  if (num_channels_p < 2) begin : g_bad_channels
    $error("num_channels_p must be at least 2");
  end
  if (len_offset_p + len_width_p > channel_width_p) begin : g_bad_len_field
    $error("length field does not fit inside a flit");
  end
  if (watchdog_cycles_p < 1) begin : g_bad_watchdog
    $error("watchdog_cycles_p must be at least 1");
  end

  typedef enum logic {
    e_idle  = 1'b0,
    e_burst = 1'b1
  } state_e;

  // Handshake: a flit moves when valid_o && yumi_i in the same cycle; yumi_o
  // is the consumer's yumi_i steered back to the channel currently shown.
  state_e                     state_r;
  logic [id_width_lp-1:0]     rr_ptr_r;
  logic [id_width_lp-1:0]     grant_r;
  logic [len_width_p-1:0]     cnt_r;

  logic [channel_width_p-1:0] chan_data [num_channels_p];
  logic [id_width_lp-1:0]     sel;
  logic [id_width_lp-1:0]     cur_id;
  logic [id_width_lp-1:0]     next_ptr;
  logic [channel_width_p-1:0] cur_data;
  logic [len_width_p-1:0]     hdr_len;
  logic                       cur_valid;
  logic                       accept;

  for (genvar i = 0; i < num_channels_p; i++) begin : g_unpack
    assign chan_data[i] = data_i[i*channel_width_p +: channel_width_p];
  end

  // First valid channel at or after rr_ptr_r, wrapping.
  always_comb begin
    logic                   found;
    logic [id_width_lp-1:0] cand;
    sel   = rr_ptr_r;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < num_channels_p; i++) begin
      cand = id_width_lp'((int'(rr_ptr_r) + i) % num_channels_p);
      if (!found && valid_i[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
  end

  assign cur_id    = (state_r == e_burst) ? grant_r : sel;
  assign cur_valid = (state_r == e_burst) ? valid_i[grant_r] : (|valid_i);
  assign cur_data  = chan_data[cur_id];
  assign hdr_len   = cur_data[len_offset_p +: len_width_p];
  assign next_ptr  = (cur_id == id_width_lp'(num_channels_p - 1)) ? '0 : cur_id + 1'b1;
  assign accept    = yumi_i & ~reset_i;

  assign valid_o    = cur_valid & ~reset_i;
  assign data_o     = cur_data;
  assign grant_id_o = cur_id;
  assign yumi_o     = accept ? (num_channels_p'(1) << cur_id) : '0;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r  <= e_idle;
      rr_ptr_r <= '0;
      grant_r  <= '0;
      cnt_r    <= '0;
    end else if (accept) begin
      case (state_r)
        e_idle: begin
          if (hdr_len == '0) begin
            rr_ptr_r <= next_ptr;
          end else begin
            state_r <= e_burst;
            grant_r <= sel;
            cnt_r   <= hdr_len;
          end
        end
        e_burst: begin
          cnt_r <= cnt_r - 1'b1;
          if (cnt_r == len_width_p'(1)) begin
            state_r  <= e_idle;
            rr_ptr_r <= next_ptr;
          end
        end
        default: state_r <= e_idle;
      endcase
    end
  end

`ifdef BSG_LINK_DOWNSTREAM_ARBITER_WATCHDOG_EN
  localparam int wd_width_lp = $clog2(watchdog_cycles_p + 1);
  localparam logic [wd_width_lp-1:0] wd_limit_lp = wd_width_lp'(watchdog_cycles_p);

  logic [wd_width_lp-1:0] stall_r;
  logic                   error_r;
  logic                   stalled;

  assign stalled = (state_r == e_burst) && !valid_i[grant_r];

  // Saturating count of consecutive starved burst cycles; error stays set until reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stall_r <= '0;
      error_r <= 1'b0;
    end else if (!stalled) begin
      stall_r <= '0;
    end else if (stall_r != wd_limit_lp) begin
      stall_r <= stall_r + 1'b1;
      if (stall_r + 1'b1 == wd_limit_lp) error_r <= 1'b1;
    end
  end

  assign error_o = error_r;
`else
  assign error_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(yumi_i && !valid_o))
        else $error("yumi_i asserted while valid_o is low");
    end
  end

endmodule
